// File: rtl/control_multi_rv32i_if.sv
// Control-unit bus: instruction/memory-ready inputs plus every datapath strobe and mux select.
interface control_multi_rv32i_if;
  logic [31:0] iInstr;
  logic        iMemReady;
  logic        oEscreveIR;
  logic        oEscrevePC;
  logic        oEscrevePCCond;
  logic        oEscrevePCBack;
  logic [1:0]  oOrigAULA;
  logic [1:0]  oOrigBULA;
  logic [1:0]  oMem2Reg;
  logic [1:0]  oOrigPC;
  logic        oIouD;
  logic        oRegWrite;
  logic        oMemRead;
  logic        oMemWrite;
  logic [4:0]  oALUControl;
  logic        oHalt;
  logic [4:0]  oState;
  logic [31:0] oRetired;

  // Control unit side: consumes IR and ready, drives the datapath controls.
  modport master (
    input  iInstr, iMemReady,
    output oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
    output oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oIouD,
    output oRegWrite, oMemRead, oMemWrite, oALUControl,
    output oHalt, oState, oRetired
  );

  // Datapath side.
  modport slave (
    output iInstr, iMemReady,
    input  oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack,
    input  oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oIouD,
    input  oRegWrite, oMemRead, oMemWrite, oALUControl,
    input  oHalt, oState, oRetired
  );
endinterface

// File: rtl/control_multi_rv32i.sv
// Multicycle RV32I control unit: fetch/decode/execute/memory/writeback FSM with
// memory-ready stalls, sticky halt on unsupported opcodes and a retired-instruction counter.
module control_multi_rv32i #(
  parameter bit WAITMEM = 1'b1
) (
  input logic                   iCLK,
  input logic                   iRST,
  control_multi_rv32i_if.master bus
);

  // ALU operation codes shared with the datapath ALU.
  localparam logic [4:0] OPAND  = 5'd0;
  localparam logic [4:0] OPOR   = 5'd1;
  localparam logic [4:0] OPXOR  = 5'd2;
  localparam logic [4:0] OPADD  = 5'd3;
  localparam logic [4:0] OPSUB  = 5'd4;
  localparam logic [4:0] OPSLT  = 5'd5;
  localparam logic [4:0] OPSLTU = 5'd6;
  localparam logic [4:0] OPSLL  = 5'd7;
  localparam logic [4:0] OPSRL  = 5'd8;
  localparam logic [4:0] OPSRA  = 5'd9;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcRType  = 7'b0110011;
  localparam logic [6:0] OpcIType  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [4:0] {
    StFetch    = 5'd0,
    StDecode   = 5'd1,
    StMemAddr  = 5'd2,
    StLoadMem  = 5'd3,
    StLoadWb   = 5'd4,
    StStoreMem = 5'd5,
    StRExe     = 5'd6,
    StIExe     = 5'd7,
    StAluWb    = 5'd8,
    StBranch   = 5'd9,
    StJal      = 5'd10,
    StJalr     = 5'd11,
    StLui      = 5'd12,
    StAuipc    = 5'd13,
    StHalt     = 5'd14
  } state_e;

  state_e      stateQ, stateD;
  logic [31:0] retiredQ, retiredD;
  logic        retire;
  logic        memReady;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic        escreveIR, escrevePC, escrevePCCond, escrevePCBack;
  logic [1:0]  origA, origB, mem2Reg, origPC;
  logic        iouD, regWrite, memRead, memWrite;
  logic [4:0]  aluControl;

  assign opcode   = bus.iInstr[6:0];
  assign funct3   = bus.iInstr[14:12];
  assign funct7   = bus.iInstr[31:25];
  assign memReady = WAITMEM ? bus.iMemReady : 1'b1;

  // funct3 -> ALU op; alt selects SUB/SRA (instruction bit 30).
  function automatic logic [4:0] aluDecode(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    unique case (f3)
      3'b000:  op = alt ? OPSUB : OPADD;
      3'b001:  op = OPSLL;
      3'b010:  op = OPSLT;
      3'b011:  op = OPSLTU;
      3'b100:  op = OPXOR;
      3'b101:  op = alt ? OPSRA : OPSRL;
      3'b110:  op = OPOR;
      default: op = OPAND;
    endcase
    return op;
  endfunction

  // State register and retired counter.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stateQ   <= StFetch;
      retiredQ <= 32'd0;
    end else begin
      stateQ   <= stateD;
      retiredQ <= retiredD;
    end
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    stateD        = stateQ;
    retire        = 1'b0;
    escreveIR     = 1'b0;
    escrevePC     = 1'b0;
    escrevePCCond = 1'b0;
    escrevePCBack = 1'b0;
    origA         = 2'b00;
    origB         = 2'b00;
    mem2Reg       = 2'b00;
    origPC        = 2'b00;
    iouD          = 1'b0;
    regWrite      = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    aluControl    = 5'd0;

    unique case (stateQ)
      StFetch: begin
        memRead    = 1'b1;
        origA      = 2'b01;
        origB      = 2'b01;
        aluControl = OPADD;
        if (memReady) begin
          escreveIR     = 1'b1;
          escrevePC     = 1'b1;
          escrevePCBack = 1'b1;
          stateD        = StDecode;
        end
      end
      StDecode: begin
        // ALUOut captures PCBack + Imm as the branch/JAL target.
        origA      = 2'b10;
        origB      = 2'b10;
        aluControl = OPADD;
        unique case (opcode)
          OpcLoad, OpcStore: stateD = StMemAddr;
          OpcRType:          stateD = StRExe;
          OpcIType:          stateD = StIExe;
          OpcBranch:         stateD = StBranch;
          OpcJal:            stateD = StJal;
          OpcJalr:           stateD = StJalr;
          OpcLui:            stateD = StLui;
          OpcAuipc:          stateD = StAuipc;
          default:           stateD = StHalt;
        endcase
      end
      StMemAddr: begin
        origB      = 2'b10;
        aluControl = OPADD;
        stateD     = opcode[5] ? StStoreMem : StLoadMem;
      end
      StLoadMem: begin
        iouD    = 1'b1;
        memRead = 1'b1;
        // MDR latches every cycle, so writeback must follow the ready cycle directly.
        if (memReady) stateD = StLoadWb;
      end
      StLoadWb: begin
        mem2Reg  = 2'b10;
        regWrite = 1'b1;
        retire   = 1'b1;
        stateD   = StFetch;
      end
      StStoreMem: begin
        iouD     = 1'b1;
        memWrite = 1'b1;
        if (memReady) begin
          retire = 1'b1;
          stateD = StFetch;
        end
      end
      StRExe: begin
        aluControl = aluDecode(funct3, funct7[5]);
        if (funct7 != 7'b0000000 && funct7 != 7'b0100000) stateD = StHalt;
        else stateD = StAluWb;
      end
      StIExe: begin
        origB      = 2'b10;
        // Bit 30 is immediate data except for SRAI.
        aluControl = aluDecode(funct3, (funct3 == 3'b101) && funct7[5]);
        stateD     = StAluWb;
      end
      StLui: begin
        origA      = 2'b11;
        origB      = 2'b10;
        aluControl = OPADD;
        stateD     = StAluWb;
      end
      StAuipc: begin
        origA      = 2'b10;
        origB      = 2'b10;
        aluControl = OPADD;
        stateD     = StAluWb;
      end
      StAluWb: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        stateD   = StFetch;
      end
      StBranch: begin
        aluControl    = OPSUB;
        escrevePCCond = 1'b1;
        origPC        = 2'b01;
        retire        = 1'b1;
        stateD        = StFetch;
      end
      StJal: begin
        mem2Reg   = 2'b01;
        regWrite  = 1'b1;
        escrevePC = 1'b1;
        origPC    = 2'b01;
        retire    = 1'b1;
        stateD    = StFetch;
      end
      StJalr: begin
        // rd gets PC (already PC+4); A was latched in DECODE so rs1==rd is safe.
        origB      = 2'b10;
        aluControl = OPADD;
        origPC     = 2'b10;
        escrevePC  = 1'b1;
        mem2Reg    = 2'b01;
        regWrite   = 1'b1;
        retire     = 1'b1;
        stateD     = StFetch;
      end
      StHalt: begin
        stateD = StHalt;
      end
      default: begin
        stateD = StHalt;
      end
    endcase

    retiredD = retiredQ + {31'd0, retire};
  end

  // Reset forces every output low, including in-flight memory strobes.
  assign bus.oEscreveIR     = escreveIR & ~iRST;
  assign bus.oEscrevePC     = escrevePC & ~iRST;
  assign bus.oEscrevePCCond = escrevePCCond & ~iRST;
  assign bus.oEscrevePCBack = escrevePCBack & ~iRST;
  assign bus.oOrigAULA      = iRST ? 2'b00 : origA;
  assign bus.oOrigBULA      = iRST ? 2'b00 : origB;
  assign bus.oMem2Reg       = iRST ? 2'b00 : mem2Reg;
  assign bus.oOrigPC        = iRST ? 2'b00 : origPC;
  assign bus.oIouD          = iouD & ~iRST;
  assign bus.oRegWrite      = regWrite & ~iRST;
  assign bus.oMemRead       = memRead & ~iRST;
  assign bus.oMemWrite      = memWrite & ~iRST;
  assign bus.oALUControl    = iRST ? 5'd0 : aluControl;
  assign bus.oHalt          = (stateQ == StHalt) & ~iRST;
  assign bus.oState         = iRST ? 5'd0 : stateQ;
  assign bus.oRetired       = iRST ? 32'd0 : retiredQ;

endmodule

// File: tb/tb_control_multi_rv32i.sv
// Bench for control_multi_rv32i: per-scenario tasks against an instruction-class latency model.
module tb_control_multi_rv32i;

  localparam logic [4:0] OPAND  = 5'd0;
  localparam logic [4:0] OPOR   = 5'd1;
  localparam logic [4:0] OPXOR  = 5'd2;
  localparam logic [4:0] OPADD  = 5'd3;
  localparam logic [4:0] OPSUB  = 5'd4;
  localparam logic [4:0] OPSLT  = 5'd5;
  localparam logic [4:0] OPSLTU = 5'd6;
  localparam logic [4:0] OPSLL  = 5'd7;
  localparam logic [4:0] OPSRL  = 5'd8;
  localparam logic [4:0] OPSRA  = 5'd9;

  localparam int KR = 0, KI = 1, KLoad = 3, KStore = 4, KBr = 5, KJal = 6;
  localparam int KJalr = 7, KLui = 8, KAuipc = 9, KRHalt = 10, KIll = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   retModel = 0;
  int   expSt[$];
  logic expRdy[$];

  control_multi_rv32i_if bus ();
  control_multi_rv32i_if bus2 ();

  control_multi_rv32i #(.WAITMEM(1'b1)) dut (.iCLK(clk), .iRST(rst), .bus(bus));
  control_multi_rv32i #(.WAITMEM(1'b0)) dut2 (.iCLK(clk), .iRST(rst), .bus(bus2));

  always #5 clk = ~clk;

  // Expected control word for a state, from the per-state output table.
  function automatic logic [21:0] expOut(input int st, input logic rdy, input logic [4:0] alu);
    logic ir, pc, pcc, pcb, iod, rw, mr, mw, hlt;
    logic [1:0] oa, ob, m2r, opc;
    logic [4:0] a;
    ir = 0; pc = 0; pcc = 0; pcb = 0; iod = 0; rw = 0; mr = 0; mw = 0; hlt = 0;
    oa = 0; ob = 0; m2r = 0; opc = 0; a = 0;
    case (st)
      0: begin mr = 1; oa = 2'b01; ob = 2'b01; a = OPADD; ir = rdy; pc = rdy; pcb = rdy; end
      1: begin oa = 2'b10; ob = 2'b10; a = OPADD; end
      2: begin ob = 2'b10; a = OPADD; end
      3: begin iod = 1; mr = 1; end
      4: begin m2r = 2'b10; rw = 1; end
      5: begin iod = 1; mw = 1; end
      6: begin a = alu; end
      7: begin ob = 2'b10; a = alu; end
      8: begin rw = 1; end
      9: begin a = OPSUB; pcc = 1; opc = 2'b01; end
      10: begin m2r = 2'b01; rw = 1; pc = 1; opc = 2'b01; end
      11: begin ob = 2'b10; a = OPADD; opc = 2'b10; pc = 1; m2r = 2'b01; rw = 1; end
      12: begin oa = 2'b11; ob = 2'b10; a = OPADD; end
      13: begin oa = 2'b10; ob = 2'b10; a = OPADD; end
      14: begin hlt = 1; end
      default: ;
    endcase
    return {ir, pc, pcc, pcb, oa, ob, m2r, opc, iod, rw, mr, mw, a, hlt};
  endfunction

  function automatic logic [21:0] actOut();
    return {bus.oEscreveIR, bus.oEscrevePC, bus.oEscrevePCCond, bus.oEscrevePCBack,
            bus.oOrigAULA, bus.oOrigBULA, bus.oMem2Reg, bus.oOrigPC, bus.oIouD,
            bus.oRegWrite, bus.oMemRead, bus.oMemWrite, bus.oALUControl, bus.oHalt};
  endfunction

  task automatic add(input int s, input logic r);
    expSt.push_back(s);
    expRdy.push_back(r);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Random encoding for mnemonic idx (0..25) with its instruction class and expected ALU op.
  task automatic pick(input int idx, output logic [31:0] ins, output int kind,
                      output logic [4:0] alu);
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  f7;
    r = $urandom(); f3 = 0; f7 = 0; kind = KR; alu = OPADD;
    case (idx)
      0:  begin f3 = 3'b000; alu = OPADD; end
      1:  begin f3 = 3'b000; f7 = 7'h20; alu = OPSUB; end
      2:  begin f3 = 3'b001; alu = OPSLL; end
      3:  begin f3 = 3'b010; alu = OPSLT; end
      4:  begin f3 = 3'b011; alu = OPSLTU; end
      5:  begin f3 = 3'b100; alu = OPXOR; end
      6:  begin f3 = 3'b101; alu = OPSRL; end
      7:  begin f3 = 3'b101; f7 = 7'h20; alu = OPSRA; end
      8:  begin f3 = 3'b110; alu = OPOR; end
      9:  begin f3 = 3'b111; alu = OPAND; end
      10: begin kind = KI; f3 = 3'b000; alu = OPADD; end
      11: begin kind = KI; f3 = 3'b010; alu = OPSLT; end
      12: begin kind = KI; f3 = 3'b011; alu = OPSLTU; end
      13: begin kind = KI; f3 = 3'b100; alu = OPXOR; end
      14: begin kind = KI; f3 = 3'b110; alu = OPOR; end
      15: begin kind = KI; f3 = 3'b111; alu = OPAND; end
      16: begin kind = KI; f3 = 3'b001; f7 = 7'h00; alu = OPSLL; end
      17: begin kind = KI; f3 = 3'b101; f7 = 7'h00; alu = OPSRL; end
      18: begin kind = KI; f3 = 3'b101; f7 = 7'h20; alu = OPSRA; end
      19: kind = KLoad;
      20: kind = KStore;
      21: kind = KBr;
      22: kind = KJal;
      23: kind = KJalr;
      24: kind = KLui;
      default: kind = KAuipc;
    endcase
    case (kind)
      KR:      ins = {f7, r[24:15], f3, r[11:7], 7'b0110011};
      KI:      ins = (idx >= 16) ? {f7, r[24:15], f3, r[11:7], 7'b0010011}
                                 : {r[31:15], f3, r[11:7], 7'b0010011};
      KLoad:   ins = {r[31:15], 3'b010, r[11:7], 7'b0000011};
      KStore:  ins = {r[31:15], 3'b010, r[11:7], 7'b0100011};
      KBr:     ins = {r[31:7], 7'b1100011};
      KJal:    ins = {r[31:7], 7'b1101111};
      KJalr:   ins = {r[31:15], 3'b000, r[11:7], 7'b1100111};
      KLui:    ins = {r[31:7], 7'b0110111};
      default: ins = {r[31:7], 7'b0010111};
    endcase
  endtask

  // Expects to start just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input string nm, input logic [31:0] ins, input int kind,
                           input logic [4:0] alu, input int wf, input int wm);
    int finalSt;
    expSt.delete(); expRdy.delete();
    for (int i = 0; i < wf; i++) add(0, 1'b0);
    add(0, 1'b1);
    add(1, rbit());
    case (kind)
      KR:     begin add(6, rbit()); add(8, rbit()); end
      KI:     begin add(7, rbit()); add(8, rbit()); end
      KLoad:  begin
        add(2, rbit());
        for (int i = 0; i < wm; i++) add(3, 1'b0);
        add(3, 1'b1); add(4, rbit());
      end
      KStore: begin
        add(2, rbit());
        for (int i = 0; i < wm; i++) add(5, 1'b0);
        add(5, 1'b1);
      end
      KBr:    add(9, rbit());
      KJal:   add(10, rbit());
      KJalr:  add(11, rbit());
      KLui:   begin add(12, rbit()); add(8, rbit()); end
      KAuipc: begin add(13, rbit()); add(8, rbit()); end
      KRHalt: begin add(6, rbit()); for (int i = 0; i < 10; i++) add(14, rbit()); end
      default: for (int i = 0; i < 10; i++) add(14, rbit());
    endcase
    for (int i = 0; i < expSt.size(); i++) begin
      bus.iInstr = ins;
      bus.iMemReady = expRdy[i];
      @(negedge clk);
      checks++;
      if (bus.oState !== 5'(expSt[i])) begin
        errors++;
        $display("FAIL %s cyc%0d state got %0d want %0d", nm, i, bus.oState, expSt[i]);
      end
      checks++;
      if (actOut() !== expOut(expSt[i], expRdy[i], alu)) begin
        errors++;
        $display("FAIL %s cyc%0d outputs got %h want %h", nm, i, actOut(),
                 expOut(expSt[i], expRdy[i], alu));
      end
      checks++;
      if (bus.oRetired !== 32'(retModel)) begin
        errors++;
        $display("FAIL %s cyc%0d retired got %0d want %0d", nm, i, bus.oRetired, retModel);
      end
      @(posedge clk);
      #1;
    end
    if (kind != KRHalt && kind != KIll) begin
      retModel++;
      finalSt = 0;
    end else begin
      finalSt = 14;
    end
    checks++;
    if (bus.oRetired !== 32'(retModel) || bus.oState !== 5'(finalSt)) begin
      errors++;
      $display("FAIL %s end retired/state got %0d/%0d want %0d/%0d", nm, bus.oRetired,
               bus.oState, retModel, finalSt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    retModel = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.iInstr = $urandom();
      bus.iMemReady = rbit();
      @(negedge clk);
      checks++;
      if (actOut() !== 22'd0 || bus.oState !== 5'd0 || bus.oRetired !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs got %h/%0d/%0d want 0/0/0", actOut(), bus.oState,
                 bus.oRetired);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    retModel = 0;
  endtask

  task automatic test_addi();
    run_instr("addi", 32'h00500093, KI, OPADD, 0, 0);
  endtask

  task automatic test_load_wait();
    run_instr("lw_wait", 32'h0000A103, KLoad, OPADD, 0, 2);
  endtask

  task automatic test_sub_illegal();
    run_instr("sub", 32'h402081B3, KR, OPSUB, 0, 0);
    run_instr("r_badf7", 32'h022081B3, KRHalt, OPADD, 1, 0);
    do_reset();
    run_instr("ecall", 32'h00000073, KIll, OPADD, 0, 0);
    do_reset();
  endtask

  task automatic test_branch_jump();
    run_instr("beq", 32'h00208463, KBr, OPADD, 0, 0);
    run_instr("jalr", 32'h000280E7, KJalr, OPADD, 0, 0);
    run_instr("jal", 32'h008000EF, KJal, OPADD, 2, 0);
  endtask

  task automatic test_reset_store();
    bus.iInstr = 32'h0020A023;
    bus.iMemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    bus.iMemReady = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.oMemWrite !== 1'b1 || bus.oState !== 5'd5) begin
      errors++;
      $display("FAIL storemem_pre got mw=%b st=%0d want 1/5", bus.oMemWrite, bus.oState);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.oMemWrite !== 1'b0 || bus.oIouD !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_mw got %b/%b want 0/0", bus.oMemWrite, bus.oIouD);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    retModel = 0;
    bus.iMemReady = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.oState !== 5'd0 || bus.oRetired !== 32'd0 || actOut() !== expOut(0, 1'b1, 5'd0))
    begin
      errors++;
      $display("FAIL rst_resume got st=%0d ret=%0d out=%h want 0/0/%h", bus.oState,
               bus.oRetired, actOut(), expOut(0, 1'b1, 5'd0));
    end
    // Leave cleanly in FETCH just after an edge.
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int kind;
    logic [4:0] alu;
    for (int n = 0; n < 40; n++) begin
      pick($urandom_range(0, 25), ins, kind, alu);
      run_instr("random", ins, kind, alu, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic test_nowait();
    int seq[9] = '{0, 1, 2, 3, 4, 0, 1, 2, 5};
    do_reset();
    bus2.iMemReady = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus2.iInstr = (i < 5) ? 32'h0000A103 : 32'h0020A023;
      @(negedge clk);
      checks++;
      if (bus2.oState !== 5'(seq[i])) begin
        errors++;
        $display("FAIL nowait cyc%0d state got %0d want %0d", i, bus2.oState, seq[i]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus2.oRetired !== 32'd2 || bus2.oState !== 5'd0) begin
      errors++;
      $display("FAIL nowait_end got ret=%0d st=%0d want 2/0", bus2.oRetired, bus2.oState);
    end
    do_reset();
  endtask

  initial begin
    bus.iInstr = 32'd0;
    bus.iMemReady = 1'b0;
    bus2.iInstr = 32'd0;
    bus2.iMemReady = 1'b0;
    test_reset();
    test_addi();
    test_load_wait();
    test_sub_illegal();
    test_branch_jump();
    test_reset_store();
    test_random();
    test_nowait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_multi_rv32i.md
# control_multi_rv32i

Multicycle control unit for the RV32I datapath. It decodes the latched instruction register and runs the fetch/decode/execute/memory/writeback state machine. Each cycle it drives every datapath control strobe and mux select, and it stalls on a memory-ready handshake. It also counts retired instructions for monitoring and halts on illegal or unsupported opcodes.

## Interface
- Parameters:
- WAITMEM, 1, 1 = honour iMemReady; 0 = memory treated as always ready
- Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iInstr  in  32  IR contents from datapath
- iMemReady  in  1  memory access completes this cycle
- oEscreveIR, oEscrevePC, oEscrevePCCond, oEscrevePCBack  out  1 each  register write strobes
- oOrigAULA  out  2  00=A, 01=PC, 10=PCBack, 11=zero
- oOrigBULA  out  2  00=B, 01=4, 10=Imm
- oMem2Reg  out  2  00=ALUOut, 01=PC, 10=MDR
- oOrigPC  out  2  00=ALU result, 01=ALUOut, 10=ALU result & ~1
- oIouD  out  1  0=PC, 1=ALUOut address
- oRegWrite, oMemRead, oMemWrite  out  1 each
- oALUControl  out  5  OPxxx code from Parametros.v
- oHalt  out  1  sticky halt flag
- oState  out  5  current state code, for monitoring
- oRetired  out  32  retired-instruction counter

## Operation
- States and codes: FETCH=0, DECODE=1, MEMADDR=2, LOADMEM=3, LOADWB=4, STOREMEM=5, REXE=6, IEXE=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, HALT=14.
- Default for every output is 0. Each state below lists only its non-zero outputs.
- FETCH: oMemRead=1, IouD=0, OrigA=01, OrigB=01, ADD, OrigPC=00.
  - When ready: EscreveIR, EscrevePC and EscrevePCBack are all 1, then go to DECODE.
  - When not ready: stay in FETCH with all strobes 0.
- DECODE: OrigA=10, OrigB=10, ADD; ALUOut becomes the branch/JAL target. Next state by opcode:
  - 0000011 or 0100011 → MEMADDR
  - 0110011 → REXE
  - 0010011 → IEXE
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else, including SYSTEM → HALT
- MEMADDR: OrigA=00, OrigB=10, ADD. Go to LOADMEM if opcode bit5=0, else STOREMEM.
- LOADMEM: IouD=1, MemRead=1. Go to LOADWB when ready, else hold.
- LOADWB: Mem2Reg=10, RegWrite=1. Go to FETCH.
- STOREMEM: IouD=1, MemWrite=1, held until ready. Go to FETCH.
- REXE: OrigA=00, OrigB=00.
  - ALU code from funct3 plus funct7 bit30: SUB/SRA when bit30=1.
  - funct7 not 0000000 or 0100000 → HALT.
  - Otherwise go to ALUWB.
- IEXE: OrigA=00, OrigB=10. ALU code from funct3; funct7 bit30 is used only for funct3=101 (SRAI). Go to ALUWB.
- LUI: OrigA=11, OrigB=10, ADD. Go to ALUWB.
- AUIPC: OrigA=10, OrigB=10, ADD. Go to ALUWB.
- ALUWB: Mem2Reg=00, RegWrite=1. Go to FETCH.
- BRANCH: OrigA=00, OrigB=00, SUB, EscrevePCCond=1, OrigPC=01. Go to FETCH.
- JAL: Mem2Reg=01, RegWrite=1, EscrevePC=1, OrigPC=01. Go to FETCH.
- JALR: OrigA=00, OrigB=10, ADD, OrigPC=10, EscrevePC=1, Mem2Reg=01, RegWrite=1. Go to FETCH.
  - rd is written with the pre-edge PC (PC+4).
  - rs1==rd is safe because A was latched in DECODE.
- HALT: all outputs 0, oHalt=1. Exits only through iRST.
- oRetired increments by 1 on each edge that leaves a terminal state (LOADWB, STOREMEM-ready, ALUWB, BRANCH, JAL, JALR) into FETCH. It wraps from FFFFFFFF to 0.

## Timing
- Outputs are combinational from state, iInstr and iMemReady. State and counter are registered on the rising edge of iCLK.
- While iRST=1, every output is forced to 0.
- Reset values: state=FETCH, oHalt=0, oRetired=0, oState=0.
- Latency with zero wait states:
  - R, I, LUI, AUIPC, store: 4 cycles
  - load: 5 cycles
  - branch, JAL, JALR: 3 cycles
- Each low-iMemReady cycle in FETCH, LOADMEM or STOREMEM adds exactly 1 cycle.
- With WAITMEM=0, iMemReady is ignored and treated as 1.
- LOADWB must immediately follow the LOADMEM ready cycle, because MDR latches every cycle.
- iRST asserted mid-access drops oMemRead/oMemWrite to 0 asynchronously. Execution resumes at FETCH after release.
- The ready-in-STOREMEM and retire-count increment happen on the same edge.

## Test plan
- addi x1,x0,5 (00500093) with ready=1: states 0,1,7,8 over 4 cycles; oALUControl=OPADD in IEXE; oRegWrite=1 only in ALUWB; oRetired 0→1.
- lw with iMemReady low 2 cycles in LOADMEM: 7 cycles total; oIouD=1 and oMemRead=1 held in all 3 LOADMEM cycles; oRetired increments once.
- sub x3,x1,x2 (402081B3) → OPSUB in REXE. Same encoding with funct7=0000001 → oState=14, oHalt=1; oRetired frozen for 10 further cycles.
- beq (00208463) → 3 cycles; oEscrevePCCond=1, oOrigPC=01 only in BRANCH; next state FETCH.
- jalr x1,0(x5) → JALR outputs OrigPC=10, Mem2Reg=01, RegWrite=1, EscrevePC=1 in a single cycle.
- iRST pulse during STOREMEM with ready=0 → oMemWrite=0 immediately; after release oState=0, oRetired=0, FETCH outputs present.
